// File: rtl/bk_pkg.sv
// Shared definitions for the multi-word Brent-Kung subtractor:
// word width, FSM state type and a constant-foldable clog2.
package bk_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_sub16.sv
// 16-bit Brent-Kung subtract slice: d = a + ~b + cin, cout = carry out.
// Ports: a, b (16b), cin in; d (16b), cout out. Purely combinational.
module bk_sub16
    import bk_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] d,
    output logic              cout
);

    logic [WORD_W-1:0] bn;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] gg;
    logic [WORD_W-1:0] pp;
    logic [WORD_W-1:0] c;

    assign bn = ~b;
    assign g  = a & bn;
    assign p  = a | bn;

    always_comb begin
        gg = g;
        pp = p;
        // Fold the incoming carry into bit 0 so every prefix G[i:0]
        // is directly the carry into bit i+1.
        gg[0] = g[0] | (p[0] & cin);
        // Up-sweep: spans 1, 2, 4, 8.
        for (int s = 1; s < WORD_W; s = s * 2) begin
            for (int i = 2 * s - 1; i < WORD_W; i = i + 2 * s) begin
                gg[i] = gg[i] | (pp[i] & gg[i-s]);
                pp[i] = pp[i] & pp[i-s];
            end
        end
        // Down-sweep: fill the remaining prefixes (11; 5,9,13; evens).
        for (int s = 4; s >= 1; s = s / 2) begin
            for (int i = 3 * s - 1; i < WORD_W; i = i + 2 * s) begin
                gg[i] = gg[i] | (pp[i] & gg[i-s]);
                pp[i] = pp[i] & pp[i-s];
            end
        end
    end

    assign c    = {gg[WORD_W-2:0], cin};
    assign d    = a ^ bn ^ c;
    assign cout = gg[WORD_W-1];

endmodule

// File: rtl/bksub_mw.sv
// Multi-word sequential subtractor D = A - B - BIN, one 16-bit word per
// clock, LSW first, borrow chained through a carry flop.
// Ports: CLK, RST_N; IN_VALID/IN_READY with A, B, BIN;
//        OUT_VALID/OUT_READY with D, BOUT (underflow), ZERO.
module bksub_mw
    import bk_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = WORD_W * WORDS
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         BIN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] D,
    output logic         BOUT,
    output logic         ZERO
);

    localparam int KW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_t            state;
    state_t            state_nx;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [KW-1:0]     k;
    logic [KW+3:0]     base;
    logic              carry;
    logic              zacc;
    logic [WORD_W-1:0] a_w;
    logic [WORD_W-1:0] b_w;
    logic [WORD_W-1:0] s_w;
    logic              s_co;
    logic              last;
    logic              w_zero;

    assign IN_READY = (state == IDLE);
    assign base     = {k, 4'b0000};
    assign a_w      = a_q[base +: WORD_W];
    assign b_w      = b_q[base +: WORD_W];
    assign last     = (k == K_LAST);
    assign w_zero   = (s_w == '0);

    bk_sub16 u_sub (
        .a    (a_w),
        .b    (b_w),
        .cin  (carry),
        .d    (s_w),
        .cout (s_co)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (IN_VALID) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (OUT_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            carry     <= 1'b1;
            zacc      <= 1'b1;
            D         <= '0;
            OUT_VALID <= 1'b0;
            BOUT      <= 1'b0;
            ZERO      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= ~BIN;
                        k     <= '0;
                        zacc  <= 1'b1;
                    end
                end
                RUN: begin
                    D[base +: WORD_W] <= s_w;
                    carry <= s_co;
                    zacc  <= zacc & w_zero;
                    k     <= last ? '0 : k + 1'b1;
                    if (last) begin
                        OUT_VALID <= 1'b1;
                        // Subtract via add of ~B: no carry out means borrow.
                        BOUT      <= ~s_co;
                        ZERO      <= zacc & w_zero;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bksub_mw.sv
// Scoreboard bench for bksub_mw: WORDS=4 and WORDS=1 instances,
// directed hand-computed vectors plus a random regression.
module tb_bksub_mw;

    typedef struct {
        logic [63:0] d;
        logic        bout;
        logic        zero;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        or_r = 1'b1;
    logic        iv4 = 1'b0;
    logic [63:0] a4 = '0;
    logic [63:0] b4 = '0;
    logic        bin4 = 1'b0;
    logic        iv1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        bin1 = 1'b0;
    wire         ir4, ov4, bo4, z4;
    wire  [63:0] d4;
    wire         ir1, ov1, bo1, z1;
    wire  [15:0] d1;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   bp_hold = 0;
    bit   rnd_ready = 0;
    exp_t q4[$];
    exp_t q1[$];

    logic        ovp4 = 0, ovp1 = 0;
    logic [63:0] dp4;
    logic [15:0] dp1;
    logic [1:0]  fp4, fp1;

    bksub_mw #(.WORDS(4)) dut4 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(iv4), .IN_READY(ir4),
        .A(a4), .B(b4), .BIN(bin4),
        .OUT_VALID(ov4), .OUT_READY(or_r),
        .D(d4), .BOUT(bo4), .ZERO(z4)
    );

    bksub_mw #(.WORDS(1)) dut1 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(iv1), .IN_READY(ir1),
        .A(a1), .B(b1), .BIN(bin1),
        .OUT_VALID(ov1), .OUT_READY(or_r),
        .D(d1), .BOUT(bo1), .ZERO(z1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bp_hold) or_r = 1'b0;
        else if (rnd_ready) or_r = 1'($urandom_range(0, 1));
        else or_r = 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ovp4 = 0;
        end else begin
            if (ov4 && !ovp4) begin
                if (q4.size() == 0) chk("spurious_valid4", 64'(ov4), 0);
                else chk("latency4", 64'(cyc - q4[0].acc), 4);
            end
            if (ov4 && ovp4) begin
                chk("hold_d4", d4, dp4);
                chk("hold_flags4", 64'({bo4, z4}), 64'(fp4));
            end
            if (ov4 && or_r && q4.size() > 0) begin
                exp_t e;
                e = q4.pop_front();
                chk("d4", d4, e.d);
                chk("bout4", 64'(bo4), 64'(e.bout));
                chk("zero4", 64'(z4), 64'(e.zero));
            end
            ovp4 = ov4;
            dp4  = d4;
            fp4  = {bo4, z4};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ovp1 = 0;
        end else begin
            if (ov1 && !ovp1) begin
                if (q1.size() == 0) chk("spurious_valid1", 64'(ov1), 0);
                else chk("latency1", 64'(cyc - q1[0].acc), 1);
            end
            if (ov1 && ovp1) begin
                chk("hold_d1", 64'(d1), 64'(dp1));
                chk("hold_flags1", 64'({bo1, z1}), 64'(fp1));
            end
            if (ov1 && or_r && q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("d1", 64'(d1), e.d);
                chk("bout1", 64'(bo1), 64'(e.bout));
                chk("zero1", 64'(z1), 64'(e.zero));
            end
            ovp1 = ov1;
            dp1  = d1;
            fp1  = {bo1, z1};
        end
    end

    task automatic send4(input logic [63:0] a, input logic [63:0] b,
                         input logic bin, input logic [63:0] ed,
                         input logic eb, input logic ez);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin; iv4 = 1'b1;
        while (!ir4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir4) begin
            chk("accept_timeout4", 64'(ir4), 1);
        end else begin
            e.d = ed; e.bout = eb; e.zero = ez; e.acc = cyc + 1;
            q4.push_back(e);
        end
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] ed,
                         input logic eb, input logic ez);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bin; iv1 = 1'b1;
        while (!ir1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir1) begin
            chk("accept_timeout1", 64'(ir1), 1);
        end else begin
            e.d = 64'(ed); e.bout = eb; e.zero = ez; e.acc = cyc + 1;
            q1.push_back(e);
        end
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q4.size() + q1.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready4", 64'(ir4), 1);
        chk("rst_out_valid4", 64'(ov4), 0);
        chk("rst_d4", d4, 0);
        chk("rst_bout4", 64'(bo4), 0);
        chk("rst_zero4", 64'(z4), 0);
        chk("rst_in_ready1", 64'(ir1), 1);
        chk("rst_out_valid1", 64'(ov1), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #3;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Borrow ripples through three all-zero words.
        send4(64'h0001_0000_0000_0000, 64'h1, 1'b0,
              64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drain();
        send4(64'h0, 64'h0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();
        send4(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
              64'h0, 1'b0, 1'b1);
        drain();
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();
        send4(64'h8000_0000_0000_0000, 64'h0000_0000_0001_0000, 1'b1,
              64'h7FFF_FFFF_FFFE_FFFF, 1'b0, 1'b0);
        send1(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        drain();
        send1(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Backpressure: result held, new operands ignored.
        bp_hold = 1;
        send4(64'h10, 64'h20, 1'b0,
              64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
        n = 0;
        while (!ov4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 64'(ov4), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(ir4), 0);
            a4 = {$urandom, $urandom};
            b4 = {$urandom, $urandom};
            iv4 = 1'b1;
            @(negedge clk);
        end
        iv4 = 1'b0;
        chk("bp_still_valid", 64'(ov4), 1);
        bp_hold = 0;
        @(negedge clk);
        chk("bp_release_ready0", 64'(ir4), 0);
        @(negedge clk);
        chk("bp_ready_back", 64'(ir4), 1);
        chk("bp_valid_clear", 64'(ov4), 0);
        drain();

        // Reset during the second RUN cycle abandons the operation.
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete();
        #1;
        chk_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_valid4", 64'(ov4), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid4", 64'(ov4), 0);
        end
        send4(64'h5, 64'h7, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
        drain();

        // Random regression against an arithmetic model.
        rnd_ready = 1;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    logic [63:0] a, b;
                    logic        bin;
                    logic [64:0] r;
                    a   = {$urandom, $urandom};
                    b   = (i % 16 == 0) ? a : {$urandom, $urandom};
                    bin = 1'($urandom_range(0, 1));
                    r   = {1'b0, a} - {1'b0, b} - 65'(bin);
                    send4(a, b, bin, r[63:0], r[64], r[63:0] == 64'h0);
                end
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    logic [15:0] a, b;
                    logic        bin;
                    logic [16:0] r;
                    a   = 16'($urandom);
                    b   = (i % 16 == 0) ? a : 16'($urandom);
                    bin = 1'($urandom_range(0, 1));
                    r   = {1'b0, a} - {1'b0, b} - 17'(bin);
                    send1(a, b, bin, r[15:0], r[16], r[15:0] == 16'h0);
                end
            end
        join
        drain();
        rnd_ready = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
